// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared state encoding and default timing constants for the
//               breakout-style game sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_LOST  = 3'd3,
        ST_CLEAR = 3'd4,
        ST_OVER  = 3'd5
    } game_state_t;

    localparam int c_lives_init   = 3;
    localparam int c_lost_frames  = 60;
    localparam int c_clear_frames = 90;
    localparam int c_blink_shift  = 5;

    // Countdown register width; covers frame counts up to 256.
    localparam int c_frame_cnt_w  = 8;

    localparam logic [1:0] c_lives_max = 2'd3;
    localparam logic [2:0] c_level_max = 3'd7;

    // Bonus life awarded on level wrap, saturating at the display maximum.
    function automatic logic [1:0] lives_bonus(input logic [1:0] lives);
        return (lives == c_lives_max) ? lives : lives + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : game_fsm_if
// Description : Event inputs and compositor/status outputs of the game
//               sequencer. The master side drives game events, the slave
//               side is the sequencer itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface game_fsm_if;

    logic       frame_tick;
    logic       start_btn;
    logic       ball_lost;
    logic       blocks_cleared;
    logic       init;
    logic       dead;
    logic       playing;
    logic       launch;
    logic [1:0] lives;
    logic [2:0] level;
    logic       banner;

    modport master (
        output frame_tick, start_btn, ball_lost, blocks_cleared,
        input  init, dead, playing, launch, lives, level, banner
    );

    modport slave (
        input  frame_tick, start_btn, ball_lost, blocks_cleared,
        output init, dead, playing, launch, lives, level, banner
    );

endinterface
`default_nettype wire

// File: rtl/frame_timer.sv
`default_nettype none
// ============================================================================
// Module      : frame_timer
// Description : Loadable frame countdown. Decrements once per frame tick while
//               enabled and stops at zero. A load always wins over a tick in
//               the same cycle so the loaded value is never pre-decremented.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int WIDTH = 8
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_value,
    input  wire logic             frame_tick,
    input  wire logic             enable,
    output logic                  at_zero
);

    logic [WIDTH-1:0] r_count;

    // Countdown register: load has priority, decrement holds at zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (enable && frame_tick && (r_count != '0)) begin
            r_count <= r_count - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign at_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/game_fsm.sv
`default_nettype none
// ============================================================================
// Module      : game_fsm
// Description : Game sequencer: title, serve, play, ball-lost and
//               level-clear pauses, game over. Tracks lives and level, drives
//               registered compositor controls and a blinking banner enable.
// Revision    : 1.0 - initial release
// ============================================================================
module game_fsm
    import game_pkg::*;
#(
    parameter int LIVES_INIT   = c_lives_init,
    parameter int LOST_FRAMES  = c_lost_frames,
    parameter int CLEAR_FRAMES = c_clear_frames,
    parameter int BLINK_SHIFT  = c_blink_shift
) (
    input  wire logic  clock,
    input  wire logic  reset,
    game_fsm_if.slave  bus
);

    localparam logic [c_frame_cnt_w-1:0] c_lost_load  = c_frame_cnt_w'(LOST_FRAMES - 1);
    localparam logic [c_frame_cnt_w-1:0] c_clear_load = c_frame_cnt_w'(CLEAR_FRAMES - 1);
    localparam logic [1:0]               c_lives_load = 2'(LIVES_INIT);

    game_state_t r_state;
    game_state_t w_state_next;

    logic [1:0]  r_lives;
    logic [1:0]  w_lives_next;
    logic [2:0]  r_level;
    logic [2:0]  w_level_next;

    // Set only once start_btn has been seen low since reset, so a button held
    // through reset release is not mistaken for a press.
    logic        r_btn_low;
    logic        w_press;

    logic        w_launch_next;
    logic        w_timer_load;
    logic [c_frame_cnt_w-1:0] w_timer_value;
    logic        w_timer_en;
    logic        w_timer_zero;
    logic        w_countdown_done;

    logic [BLINK_SHIFT:0] r_blink;
    logic [BLINK_SHIFT:0] w_blink_next;

    logic        r_init;
    logic        r_dead;
    logic        r_playing;
    logic        r_launch;
    logic        r_banner;

    assign w_press          = bus.start_btn & r_btn_low;
    assign w_timer_en       = (r_state == ST_LOST) || (r_state == ST_CLEAR);
    assign w_countdown_done = bus.frame_tick & w_timer_zero;
    assign w_blink_next     = bus.frame_tick ? r_blink + {{BLINK_SHIFT{1'b0}}, 1'b1} : r_blink;

    frame_timer #(
        .WIDTH (c_frame_cnt_w)
    ) u_frame_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (w_timer_load),
        .load_value (w_timer_value),
        .frame_tick (bus.frame_tick),
        .enable     (w_timer_en),
        .at_zero    (w_timer_zero)
    );

    // Start button history used for press (rising edge) detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_low <= 1'b0;
        end else begin
            r_btn_low <= ~bus.start_btn;
        end
    end

    // Free-running frame counter feeding the banner blink.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink <= '0;
        end else begin
            r_blink <= w_blink_next;
        end
    end

    // State, lives and level registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_lives <= 2'd0;
            r_level <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_lives <= w_lives_next;
            r_level <= w_level_next;
        end
    end

    // Next-state, lives/level update and countdown load decode.
    always_comb begin
        w_state_next  = r_state;
        w_lives_next  = r_lives;
        w_level_next  = r_level;
        w_launch_next = 1'b0;
        w_timer_load  = 1'b0;
        w_timer_value = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_lives_next = c_lives_load;
                    w_level_next = 3'd0;
                    w_state_next = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (w_press) begin
                    w_launch_next = 1'b1;
                    w_state_next  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // Clearing the board wins over a simultaneous lost ball.
                if (bus.blocks_cleared) begin
                    w_timer_load  = 1'b1;
                    w_timer_value = c_clear_load;
                    w_state_next  = ST_CLEAR;
                end else if (bus.ball_lost) begin
                    if (r_lives != 2'd0) begin
                        w_lives_next = r_lives - 2'd1;
                    end
                    w_timer_load  = 1'b1;
                    w_timer_value = c_lost_load;
                    w_state_next  = ST_LOST;
                end
            end
            ST_LOST: begin
                if (w_countdown_done) begin
                    w_state_next = (r_lives != 2'd0) ? ST_SERVE : ST_OVER;
                end
            end
            ST_CLEAR: begin
                if (w_countdown_done) begin
                    if (r_level == c_level_max) begin
                        w_level_next = 3'd0;
                        w_lives_next = lives_bonus(r_lives);
                    end else begin
                        w_level_next = r_level + 3'd1;
                    end
                    w_state_next = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (w_press) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Registered compositor controls, decoded from the state being entered.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_init    <= 1'b1;
            r_dead    <= 1'b0;
            r_playing <= 1'b0;
            r_launch  <= 1'b0;
            r_banner  <= 1'b0;
        end else begin
            r_init    <= (w_state_next == ST_IDLE);
            r_dead    <= (w_state_next == ST_LOST) || (w_state_next == ST_OVER);
            r_playing <= (w_state_next == ST_PLAY);
            r_launch  <= w_launch_next;
            r_banner  <= ((w_state_next == ST_IDLE) || (w_state_next == ST_OVER))
                         ? w_blink_next[BLINK_SHIFT] : 1'b0;
        end
    end

    assign bus.init    = r_init;
    assign bus.dead    = r_dead;
    assign bus.playing = r_playing;
    assign bus.launch  = r_launch;
    assign bus.lives   = r_lives;
    assign bus.level   = r_level;
    assign bus.banner  = r_banner;

endmodule
`default_nettype wire
